// File: rtl/flipflop_tint_bank.sv
// ---------------------------------------------------------------------------
// flipflop_tint_bank
//   Multi-channel interrupt latch bank with lowest-index arbitration and a
//   Req/Ack handshake towards the CPU control sequencer.
//
//   Each channel captures its INT input either as a rising edge (latched until
//   acknowledged or cleared) or as a level (Pending follows INT). notIFF1
//   flushes all pending state, Mask blocks capture and request per channel.
//   The FSM latches the lowest eligible channel into Vector, holds it while
//   Req is high, and inserts one low cycle (GAP) after every acknowledge.
//
// Ports
//   Clk            in   1         system clock, rising edge
//   P2_Reset       in   1         synchronous active-high reset
//   INT            in   CHANNELS  raw interrupt inputs (synchronous to Clk)
//   notIFF1        in   1         1 = interrupts disabled, flush pending/Req
//   Mask           in   CHANNELS  1 = channel may capture and request
//   Clear_Pending  in   CHANNELS  per-channel synchronous clear of pending
//   Ack            in   1         single-cycle acknowledge from sequencer
//   Req            out  1         registered interrupt request
//   Vector         out  IDX_W     registered index of the requesting channel
//   Pending        out  CHANNELS  registered pending vector
// ---------------------------------------------------------------------------
module flipflop_tint_bank #(
  parameter int                     CHANNELS  = 8,
  parameter int                     IDX_W     = 3,
  parameter logic [CHANNELS-1:0]    EDGE_MODE = '1
) (
  input  logic                Clk,
  input  logic                P2_Reset,
  input  logic [CHANNELS-1:0] INT,
  input  logic                notIFF1,
  input  logic [CHANNELS-1:0] Mask,
  input  logic [CHANNELS-1:0] Clear_Pending,
  input  logic                Ack,
  output logic                Req,
  output logic [IDX_W-1:0]    Vector,
  output logic [CHANNELS-1:0] Pending
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t              state;
  logic [CHANNELS-1:0] int_d;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] eligible;
  logic [CHANNELS-1:0] hold_next;   // next pending, ignoring ack-clear
  logic [CHANNELS-1:0] pending_next;
  logic [CHANNELS-1:0] sel;         // one-hot of the latched Vector
  logic [IDX_W-1:0]    first_idx;
  logic                any_eligible;
  logic                cancel;
  logic                ack_fire;

  assign rise         = INT & ~int_d;
  assign eligible     = Pending & Mask;
  assign any_eligible = |eligible;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    sel       = '0;
    first_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (eligible[i]) first_idx = IDX_W'(i);
      if (Vector == IDX_W'(i)) sel[i] = 1'b1;
    end
  end

  always_comb begin
    hold_next = Pending;
    for (int i = 0; i < CHANNELS; i++) begin
      if (notIFF1 || Clear_Pending[i]) hold_next[i] = 1'b0;
      else if (!Mask[i])               hold_next[i] = Pending[i];
      else if (EDGE_MODE[i])           hold_next[i] = Pending[i] | rise[i];
      else                             hold_next[i] = INT[i];
    end
  end

  // The request is withdrawn at the same edge its channel stops being
  // eligible (clear, mask, level drop or notIFF1), so the sequencer never
  // acknowledges a channel that has already gone away.
  assign cancel   = (state == REQ) && !(|(hold_next & Mask & sel));
  assign ack_fire = (state == REQ) && !cancel && Ack;

  // Ack-clear applies to edge channels only, and a fresh edge beats it.
  assign pending_next = ack_fire ? (hold_next & ~(sel & EDGE_MODE & ~rise))
                                 : hold_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (P2_Reset) begin
      Pending <= '0;
      int_d   <= '1;  // an INT already high at release is not an edge
      Req     <= 1'b0;
      Vector  <= '0;
      state   <= IDLE;
    end else begin
      Pending <= pending_next;
      int_d   <= INT;
      case (state)
        IDLE: begin
          if (!notIFF1 && any_eligible) begin
            Vector <= first_idx;
            Req    <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (cancel) begin
            Req   <= 1'b0;
            state <= IDLE;
          end else if (Ack) begin
            Req   <= 1'b0;
            state <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          Req   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flipflop_tint_bank.sv
// ---------------------------------------------------------------------------
// tb_flipflop_tint_bank
//   Directed bench for flipflop_tint_bank (8 channels, channel 0 level mode,
//   channels 1..7 edge mode). Inputs change 1 time unit after the rising edge
//   and outputs are inspected at that same point.
// ---------------------------------------------------------------------------
module tb_flipflop_tint_bank;

  logic       Clk = 1'b0;
  logic       P2_Reset;
  logic [7:0] INT;
  logic       notIFF1;
  logic [7:0] Mask;
  logic [7:0] Clear_Pending;
  logic       Ack;
  logic       Req;
  logic [2:0] Vector;
  logic [7:0] Pending;

  int checks   = 0;
  int failures = 0;

  flipflop_tint_bank #(
    .CHANNELS  (8),
    .IDX_W     (3),
    .EDGE_MODE (8'hFE)
  ) dut (
    .Clk           (Clk),
    .P2_Reset      (P2_Reset),
    .INT           (INT),
    .notIFF1       (notIFF1),
    .Mask          (Mask),
    .Clear_Pending (Clear_Pending),
    .Ack           (Ack),
    .Req           (Req),
    .Vector        (Vector),
    .Pending       (Pending)
  );

  always #5 Clk = ~Clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic test_reset;
    P2_Reset = 1'b1; INT = 8'h00; notIFF1 = 1'b0; Mask = 8'hFF;
    Clear_Pending = 8'h00; Ack = 1'b0;
    tick(2);
    checks++; if (Pending !== 8'h00) begin $display("FAIL reset_pending got=%h exp=00", Pending); failures++; end
    checks++; if (Req !== 1'b0)      begin $display("FAIL reset_req got=%b exp=0", Req); failures++; end
    checks++; if (Vector !== 3'd0)   begin $display("FAIL reset_vector got=%0d exp=0", Vector); failures++; end
    P2_Reset = 1'b0;
    tick();
    checks++; if (Req !== 1'b0) begin $display("FAIL reset_idle_req got=%b exp=0", Req); failures++; end
  endtask

  task automatic test_basic;
    INT = 8'h08;
    tick();
    checks++; if (Pending !== 8'h08) begin $display("FAIL basic_pending got=%h exp=08", Pending); failures++; end
    checks++; if (Req !== 1'b0)      begin $display("FAIL basic_req_latency got=%b exp=0", Req); failures++; end
    tick();
    checks++; if (Req !== 1'b1 || Vector !== 3'd3) begin $display("FAIL basic_req got=%b/%0d exp=1/3", Req, Vector); failures++; end
    Ack = 1'b1; tick(); Ack = 1'b0;
    checks++; if (Pending !== 8'h00 || Req !== 1'b0) begin $display("FAIL basic_ack got=%h/%b exp=00/0", Pending, Req); failures++; end
    tick(2);
    checks++; if (Req !== 1'b0) begin $display("FAIL basic_no_rereq got=%b exp=0", Req); failures++; end
    INT = 8'h00; tick();
  endtask

  task automatic test_priority;
    INT = 8'h24;
    tick(2);
    checks++; if (Req !== 1'b1 || Vector !== 3'd2) begin $display("FAIL prio_first got=%b/%0d exp=1/2", Req, Vector); failures++; end
    Ack = 1'b1; tick(); Ack = 1'b0;
    checks++; if (Pending !== 8'h20 || Req !== 1'b0) begin $display("FAIL prio_ack got=%h/%b exp=20/0", Pending, Req); failures++; end
    tick();
    checks++; if (Req !== 1'b0) begin $display("FAIL prio_gap got=%b exp=0", Req); failures++; end
    tick();
    checks++; if (Req !== 1'b1 || Vector !== 3'd5) begin $display("FAIL prio_second got=%b/%0d exp=1/5", Req, Vector); failures++; end
    Ack = 1'b1; tick(); Ack = 1'b0;
    checks++; if (Pending !== 8'h00) begin $display("FAIL prio_drain got=%h exp=00", Pending); failures++; end
    INT = 8'h00; tick(2);
  endtask

  task automatic test_hold_vector;
    INT = 8'h10;
    tick(2);
    INT = 8'h12;
    tick(2);
    checks++; if (Pending !== 8'h12 || Vector !== 3'd4 || Req !== 1'b1) begin
      $display("FAIL hold_vector got=%h/%0d/%b exp=12/4/1", Pending, Vector, Req); failures++; end
    Ack = 1'b1; tick(); Ack = 1'b0;
    checks++; if (Pending !== 8'h02) begin $display("FAIL hold_ack got=%h exp=02", Pending); failures++; end
    tick(2);
    checks++; if (Req !== 1'b1 || Vector !== 3'd1) begin $display("FAIL hold_next got=%b/%0d exp=1/1", Req, Vector); failures++; end
    notIFF1 = 1'b1; tick();
    checks++; if (Req !== 1'b0 || Pending !== 8'h00) begin $display("FAIL iff_cancel got=%b/%h exp=0/00", Req, Pending); failures++; end
    notIFF1 = 1'b0; tick(2);
    checks++; if (Req !== 1'b0 || Pending !== 8'h00) begin $display("FAIL iff_stays got=%b/%h exp=0/00", Req, Pending); failures++; end
    INT = 8'h00; tick();
  endtask

  task automatic test_ack_collide;
    INT = 8'h08;
    tick(2);
    INT = 8'h00;
    tick();
    checks++; if (Req !== 1'b1 || Pending !== 8'h08) begin $display("FAIL coll_latched got=%b/%h exp=1/08", Req, Pending); failures++; end
    INT = 8'h08; Ack = 1'b1; tick(); Ack = 1'b0;
    checks++; if (Pending !== 8'h08 || Req !== 1'b0) begin $display("FAIL coll_set_wins got=%h/%b exp=08/0", Pending, Req); failures++; end
    tick(2);
    checks++; if (Req !== 1'b1 || Vector !== 3'd3) begin $display("FAIL coll_rereq got=%b/%0d exp=1/3", Req, Vector); failures++; end
    Clear_Pending = 8'h08; Ack = 1'b1; tick(); Clear_Pending = 8'h00; Ack = 1'b0;
    checks++; if (Pending !== 8'h00 || Req !== 1'b0) begin $display("FAIL coll_clear_cancel got=%h/%b exp=00/0", Pending, Req); failures++; end
    INT = 8'h00; tick(2);
    checks++; if (Req !== 1'b0) begin $display("FAIL coll_after got=%b exp=0", Req); failures++; end
  endtask

  task automatic test_level;
    INT = 8'h01;
    tick();
    checks++; if (Pending !== 8'h01) begin $display("FAIL lvl_pending got=%h exp=01", Pending); failures++; end
    for (int r = 0; r < 2; r++) begin
      tick();
      checks++; if (Req !== 1'b1 || Vector !== 3'd0) begin $display("FAIL lvl_req%0d got=%b/%0d exp=1/0", r, Req, Vector); failures++; end
      Ack = 1'b1; tick(); Ack = 1'b0;
      checks++; if (Pending !== 8'h01 || Req !== 1'b0) begin $display("FAIL lvl_ack%0d got=%h/%b exp=01/0", r, Pending, Req); failures++; end
      tick();
    end
    tick();
    checks++; if (Req !== 1'b1) begin $display("FAIL lvl_req_again got=%b exp=1", Req); failures++; end
    INT = 8'h00; tick();
    checks++; if (Req !== 1'b0 || Pending !== 8'h00) begin $display("FAIL lvl_drop_cancel got=%b/%h exp=0/00", Req, Pending); failures++; end
    tick(2);
    checks++; if (Req !== 1'b0) begin $display("FAIL lvl_stays got=%b exp=0", Req); failures++; end
  endtask

  task automatic test_reset_edge;
    P2_Reset = 1'b1; INT = 8'h40; tick(2); P2_Reset = 1'b0;
    tick();
    checks++; if (Pending !== 8'h00) begin $display("FAIL rst_no_capture got=%h exp=00", Pending); failures++; end
    INT = 8'h00; Mask = 8'hBF; tick();
    INT = 8'h40; tick();
    checks++; if (Pending !== 8'h00) begin $display("FAIL mask_no_capture got=%h exp=00", Pending); failures++; end
    Mask = 8'hFF; tick(2);
    checks++; if (Pending !== 8'h00 || Req !== 1'b0) begin $display("FAIL mask_release got=%h/%b exp=00/0", Pending, Req); failures++; end
    INT = 8'h00; tick();
    INT = 8'h08; tick(2);
    checks++; if (Req !== 1'b1) begin $display("FAIL rst_req_setup got=%b exp=1", Req); failures++; end
    P2_Reset = 1'b1; tick();
    checks++; if (Req !== 1'b0 || Vector !== 3'd0 || Pending !== 8'h00) begin
      $display("FAIL rst_during_req got=%b/%0d/%h exp=0/0/00", Req, Vector, Pending); failures++; end
    P2_Reset = 1'b0; INT = 8'h00; tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_hold_vector();
    test_ack_collide();
    test_level();
    test_reset_edge();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
